// File: rtl/gravity_tx_pkg.sv
// Shared types and constants for the gravity result transmitter: state encoding,
// UART frame header, frame lengths and checksum width.
package gravity_tx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LATCH  = 4'd1,
        ST_DIV_X  = 4'd2,
        ST_DIV_Y  = 4'd3,
        ST_RESULT = 4'd4,
        ST_LOAD   = 4'd5,
        ST_TX     = 4'd6,
        ST_DONE   = 4'd7
    } state_e;

    localparam logic [7:0] FRAME_HEADER    = 8'hA5;
    localparam int         FRAME_LEN_BASE  = 6;
    localparam int         FRAME_LEN_SUM_S = 9;
    localparam int         CHECKSUM_WIDTH  = 8;
    // start + 8 data + stop
    localparam int         UART_BITS       = 10;

endpackage

// File: rtl/gravity_div_seq.sv
// Unsigned sequential restoring divider: one quotient bit per cycle, done pulses
// DIVIDEND_W cycles after start. The caller never issues a zero divisor.
module gravity_div_seq #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  done_q;

    logic [DIVISOR_W:0]    shifted;
    logic                  fits;
    logic [DIVISOR_W-1:0]  rem_next;

    always_comb begin
        shifted  = {rem_q, quot_q[DIVIDEND_W-1]};
        fits     = shifted >= {1'b0, divisor_i};
        rem_next = fits ? DIVISOR_W'(shifted - {1'b0, divisor_i}) : shifted[DIVISOR_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start_i) begin
            quot_q <= dividend_i;
            rem_q  <= '0;
            cnt_q  <= CNT_W'(DIVIDEND_W);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            quot_q <= {quot_q[DIVIDEND_W-2:0], fits};
            rem_q  <= rem_next;
            cnt_q  <= cnt_q - CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy_o     = (cnt_q != '0);
    assign done_o     = done_q;
    assign quotient_o = quot_q;

endmodule

// File: rtl/gravity_result_tx.sv
// Latches gravity sums on a start edge, divides to a saturated centroid and sends it
// as a UART frame while holding oBUSY. `GRAVITY_TX_SUM_S_EN appends the pixel count.
module gravity_result_tx
    import gravity_tx_pkg::*;
#(
    parameter int SUM_S_WIDTH  = 20,
    parameter int SUM_SX_WIDTH = 28,
    parameter int SUM_SY_WIDTH = 28,
    parameter int COORD_WIDTH  = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                    CCLK,
    input  logic                    RST_N,
    input  logic                    iSTART_TRIG,
    input  logic [SUM_S_WIDTH-1:0]  iSUM_S,
    input  logic [SUM_SX_WIDTH-1:0] iSUM_SX,
    input  logic [SUM_SY_WIDTH-1:0] iSUM_SY,
    output logic                    oBUSY,
    output logic [COORD_WIDTH-1:0]  oCX,
    output logic [COORD_WIDTH-1:0]  oCY,
    output logic                    oVALID,
    output logic                    oNO_TARGET,
    output logic                    oTXD,
    output logic [3:0]              oSTATE
);

    localparam int DIV_W = (SUM_SX_WIDTH > SUM_SY_WIDTH) ? SUM_SX_WIDTH : SUM_SY_WIDTH;
    localparam int CW    = $clog2(CLKS_PER_BIT);
`ifdef GRAVITY_TX_SUM_S_EN
    localparam int FRAME_LEN = FRAME_LEN_SUM_S;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    state_e                  state_q, state_d;
    logic                    trig_q;
    logic [SUM_S_WIDTH-1:0]  s_q, s_d;
    logic [SUM_SX_WIDTH-1:0] sx_q, sx_d;
    logic [SUM_SY_WIDTH-1:0] sy_q, sy_d;
    logic [DIV_W-1:0]        qx_q, qx_d, qy_q, qy_d;
    logic [COORD_WIDTH-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic                    nt_q, nt_d, valid_q, valid_d, busy_q, busy_d;
    logic [3:0]              idx_q, idx_d, bit_q, bit_d;
    logic [UART_BITS-1:0]    shift_q, shift_d;
    logic [CW-1:0]           clk_q, clk_d;

    logic                    start_edge, div_start, div_busy, div_done;
    logic [DIV_W-1:0]        div_dividend, div_quot;
    logic [7:0]              tx_byte;
    logic [CHECKSUM_WIDTH-1:0] checksum;
    logic                    last_byte, stop_bit;
    logic [CW-1:0]           bit_end;

    function automatic logic [COORD_WIDTH-1:0] saturate(input logic [DIV_W-1:0] q);
        if ((q >> COORD_WIDTH) != '0) return '1;
        return q[COORD_WIDTH-1:0];
    endfunction

    assign start_edge   = iSTART_TRIG & ~trig_q;
    assign div_dividend = (state_q == ST_DIV_X) ? DIV_W'(sy_q) : DIV_W'(sx_q);

    gravity_div_seq #(
        .DIVIDEND_W(DIV_W),
        .DIVISOR_W (SUM_S_WIDTH)
    ) u_div (
        .clk       (CCLK),
        .rst_n     (RST_N),
        .start_i   (div_start),
        .dividend_i(div_dividend),
        .divisor_i (s_q),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quot)
    );

`ifdef GRAVITY_TX_SUM_S_EN
    logic [23:0] s_ext;
    assign s_ext = 24'(s_q);
`endif

    always_comb begin
        checksum = FRAME_HEADER + cx_q[15:8] + cx_q[7:0] + cy_q[15:8] + cy_q[7:0]
`ifdef GRAVITY_TX_SUM_S_EN
                 + s_ext[23:16] + s_ext[15:8] + s_ext[7:0]
`endif
                 ;
        case (idx_q)
            4'd0:    tx_byte = FRAME_HEADER;
            4'd1:    tx_byte = cx_q[15:8];
            4'd2:    tx_byte = cx_q[7:0];
            4'd3:    tx_byte = cy_q[15:8];
            4'd4:    tx_byte = cy_q[7:0];
`ifdef GRAVITY_TX_SUM_S_EN
            4'd5:    tx_byte = s_ext[23:16];
            4'd6:    tx_byte = s_ext[15:8];
            4'd7:    tx_byte = s_ext[7:0];
`endif
            default: tx_byte = checksum;
        endcase
    end

    // Between bytes LOAD holds the line high for one cycle, so that stop bit is
    // cut short by one cycle to keep it exactly one bit period.
    assign last_byte = (idx_q == LAST_IDX);
    assign stop_bit  = (bit_q == 4'(UART_BITS - 1));
    assign bit_end   = (stop_bit && !last_byte) ? CW'(CLKS_PER_BIT - 2) : CW'(CLKS_PER_BIT - 1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        nt_d      = nt_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        idx_d     = idx_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        clk_d     = clk_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    s_d     = iSUM_S;
                    sx_d    = iSUM_SX;
                    sy_d    = iSUM_SY;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                busy_d = 1'b1;
                if (s_q == '0) begin
                    qx_d    = '1;
                    qy_d    = '1;
                    state_d = ST_RESULT;
                end else if (!div_busy) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV_X;
                end
            end
            ST_DIV_X: begin
                if (div_done) begin
                    qx_d      = div_quot;
                    div_start = 1'b1;
                    state_d   = ST_DIV_Y;
                end
            end
            ST_DIV_Y: begin
                if (div_done) begin
                    qy_d    = div_quot;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                cx_d    = saturate(qx_q);
                cy_d    = saturate(qy_q);
                nt_d    = (s_q == '0);
                valid_d = 1'b1;
                idx_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d = {1'b1, tx_byte, 1'b0};
                bit_d   = '0;
                clk_d   = '0;
                state_d = ST_TX;
            end
            ST_TX: begin
                if (clk_q == bit_end) begin
                    clk_d = '0;
                    if (stop_bit) begin
                        idx_d = idx_q + 4'd1;
                        if (last_byte) begin
                            busy_d  = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {1'b0, shift_q[UART_BITS-1:1]};
                    end
                end else begin
                    clk_d = clk_q + CW'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            trig_q  <= 1'b0;
            s_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            nt_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            clk_q   <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= iSTART_TRIG;
            s_q     <= s_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            nt_q    <= nt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            clk_q   <= clk_d;
        end
    end

    assign oBUSY      = busy_q;
    assign oCX        = cx_q;
    assign oCY        = cy_q;
    assign oVALID     = valid_q;
    assign oNO_TARGET = nt_q;
    assign oTXD       = (state_q == ST_TX) ? shift_q[0] : 1'b1;
    assign oSTATE     = state_q;

endmodule

// File: tb/tb_gravity_result_tx.sv
// Randomised scoreboard bench for gravity_result_tx: a UART receiver, a centroid
// monitor and a bit-timing monitor compare against a division-based reference model.
module tb_gravity_result_tx;

    localparam int CLKS = 16;

    typedef struct {
        logic [15:0] cx;
        logic [15:0] cy;
        logic        nt;
    } cent_t;

    logic        CCLK = 1'b0;
    logic        RST_N;
    logic        iSTART_TRIG;
    logic [19:0] iSUM_S;
    logic [27:0] iSUM_SX;
    logic [27:0] iSUM_SY;
    logic        oBUSY;
    logic [15:0] oCX;
    logic [15:0] oCY;
    logic        oVALID;
    logic        oNO_TARGET;
    logic        oTXD;
    logic [3:0]  oSTATE;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int busy_fall_cnt = 0;
    int bytes_rx = 0;
    int reset_epoch = 0;

    logic [7:0] exp_bytes[$];
    cent_t      exp_cent[$];

    gravity_result_tx #(
        .SUM_S_WIDTH (20),
        .SUM_SX_WIDTH(28),
        .SUM_SY_WIDTH(28),
        .COORD_WIDTH (16),
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .CCLK       (CCLK),
        .RST_N      (RST_N),
        .iSTART_TRIG(iSTART_TRIG),
        .iSUM_S     (iSUM_S),
        .iSUM_SX    (iSUM_SX),
        .iSUM_SY    (iSUM_SY),
        .oBUSY      (oBUSY),
        .oCX        (oCX),
        .oCY        (oCY),
        .oVALID     (oVALID),
        .oNO_TARGET (oNO_TARGET),
        .oTXD       (oTXD),
        .oSTATE     (oSTATE)
    );

    always #5 CCLK = ~CCLK;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: plain integer division, saturation and byte-wise framing.
    task automatic push_expect(input int unsigned s, input int unsigned sx, input int unsigned sy);
        int unsigned cx, cy, sum;
        logic [7:0]  frame[$];
        cent_t       c;
        if (s == 0) begin
            cx = 65535;
            cy = 65535;
        end else begin
            cx = sx / s;
            cy = sy / s;
            if (cx > 65535) cx = 65535;
            if (cy > 65535) cy = 65535;
        end
        c.cx = cx[15:0];
        c.cy = cy[15:0];
        c.nt = (s == 0);
        exp_cent.push_back(c);
        frame = {8'hA5, cx[15:8], cx[7:0], cy[15:8], cy[7:0]};
`ifdef GRAVITY_TX_SUM_S_EN
        frame.push_back(8'((s >> 16) & 32'hF));
        frame.push_back(8'((s >> 8) & 32'hFF));
        frame.push_back(8'(s & 32'hFF));
`endif
        sum = 0;
        foreach (frame[i]) sum += frame[i];
        frame.push_back(8'(sum % 256));
        foreach (frame[i]) exp_bytes.push_back(frame[i]);
    endtask

    // UART receiver: samples mid-bit and scores each byte against the queue.
    initial begin : uart_rx
        logic [7:0] data;
        logic       start_b, stop_b;
        int         epoch;
        forever begin
            @(negedge CCLK);
            if (RST_N && oTXD == 1'b0) begin
                epoch = reset_epoch;
                repeat (CLKS / 2) @(negedge CCLK);
                start_b = oTXD;
                for (int b = 0; b < 8; b++) begin
                    repeat (CLKS) @(negedge CCLK);
                    data[b] = oTXD;
                end
                repeat (CLKS) @(negedge CCLK);
                stop_b = oTXD;
                if (epoch == reset_epoch) begin
                    check("start_bit", start_b == 1'b0, start_b, 0);
                    check("stop_bit", stop_b == 1'b1, stop_b, 1);
                    check("byte_expected", exp_bytes.size() != 0, exp_bytes.size(), 1);
                    if (exp_bytes.size() != 0) begin
                        logic [7:0] e;
                        e = exp_bytes.pop_front();
                        check("frame_byte", data == e, data, e);
                    end
                    bytes_rx++;
                end
            end
        end
    end

    initial begin : cent_mon
        cent_t e;
        forever begin
            @(negedge CCLK);
            if (RST_N && oVALID) begin
                valid_cnt++;
                check("cent_expected", exp_cent.size() != 0, exp_cent.size(), 1);
                if (exp_cent.size() != 0) begin
                    e = exp_cent.pop_front();
                    check("oCX", oCX == e.cx, oCX, e.cx);
                    check("oCY", oCY == e.cy, oCY, e.cy);
                    check("oNO_TARGET", oNO_TARGET == e.nt, oNO_TARGET, e.nt);
                end
            end
        end
    end

    // Every line transition inside a frame, and the fall of oBUSY, must land on a bit boundary.
    initial begin : timing_mon
        longint cyc, last;
        bit     ref_ok;
        logic   prev_txd, prev_busy;
        cyc = 0; last = 0; ref_ok = 0; prev_txd = 1'b1; prev_busy = 1'b0;
        forever begin
            @(negedge CCLK);
            cyc++;
            if (!RST_N) begin
                ref_ok = 0;
            end else begin
                if (oBUSY && !prev_busy) ref_ok = 0;
                if (oTXD != prev_txd && oBUSY) begin
                    if (ref_ok) check("bit_period", (cyc - last) % CLKS == 0, cyc - last, CLKS);
                    last = cyc;
                    ref_ok = 1;
                end
                if (!oBUSY && prev_busy) begin
                    busy_fall_cnt++;
                    if (ref_ok) check("busy_fall_at_stop_end", (cyc - last) % CLKS == 0, cyc - last, CLKS);
                    ref_ok = 0;
                end
            end
            prev_txd = oTXD;
            prev_busy = oBUSY;
        end
    end

    task automatic trigger(input int unsigned s, input int unsigned sx, input int unsigned sy, input int hold);
        @(negedge CCLK);
        iSUM_S = s[19:0];
        iSUM_SX = sx[27:0];
        iSUM_SY = sy[27:0];
        iSTART_TRIG = 1'b1;
        @(negedge CCLK);
        check("busy_low_in_latch", oBUSY == 1'b0, oBUSY, 0);
        @(negedge CCLK);
        check("busy_rise", oBUSY == 1'b1, oBUSY, 1);
        repeat (hold) @(negedge CCLK);
        iSTART_TRIG = 1'b0;
        iSUM_S = 20'($urandom);
        iSUM_SX = 28'($urandom);
        iSUM_SY = 28'($urandom);
    endtask

    task automatic run_txn(input int unsigned s, input int unsigned sx, input int unsigned sy,
                           input int hold, input bit retrig);
        int v0, f0, cycles;
        push_expect(s, sx, sy);
        v0 = valid_cnt;
        f0 = busy_fall_cnt;
        trigger(s, sx, sy, hold);
        if (retrig) begin
            repeat (300) @(negedge CCLK);
            iSTART_TRIG = 1'b1;
            repeat (8) @(negedge CCLK);
            iSTART_TRIG = 1'b0;
        end
        cycles = 0;
        while (oBUSY && cycles < 20000) begin
            @(negedge CCLK);
            cycles++;
        end
        check("busy_fall_timeout", oBUSY == 1'b0, oBUSY, 0);
        repeat (40) @(negedge CCLK);
        check("valid_pulses", valid_cnt - v0 == 1, valid_cnt - v0, 1);
        check("busy_falls", busy_fall_cnt - f0 == 1, busy_fall_cnt - f0, 1);
        check("frame_drained", exp_bytes.size() == 0, exp_bytes.size(), 0);
        check("idle_after", oBUSY == 1'b0 && oSTATE == 4'd0, {oBUSY, oSTATE}, 0);
    endtask

    task automatic check_reset_state;
        check("rst_busy", oBUSY == 1'b0, oBUSY, 0);
        check("rst_txd", oTXD == 1'b1, oTXD, 1);
        check("rst_state", oSTATE == 4'd0, oSTATE, 0);
        check("rst_valid", oVALID == 1'b0, oVALID, 0);
        check("rst_cx", oCX == 16'd0, oCX, 0);
        check("rst_cy", oCY == 16'd0, oCY, 0);
        check("rst_no_target", oNO_TARGET == 1'b0, oNO_TARGET, 0);
    endtask

    initial begin : main
        int b0, cycles;
        int unsigned s, sx, sy;
        RST_N = 1'b0;
        iSTART_TRIG = 1'b0;
        iSUM_S = '0;
        iSUM_SX = '0;
        iSUM_SY = '0;
        repeat (3) @(negedge CCLK);
        check_reset_state();
        #2 RST_N = 1'b1;
        repeat (3) @(negedge CCLK);

        run_txn(100, 32000, 24000, 512, 0);
        run_txn(0, 12345, 6789, 4, 0);
        run_txn(3, 10, 28'h0FFFFFF, 4, 0);
        run_txn(100, 32000, 24000, 4, 1);

        // Abort in the middle of byte 3, then confirm the next frame is clean.
        push_expect(5000, 1234567, 7654321);
        b0 = bytes_rx;
        trigger(5000, 1234567, 7654321, 4);
        cycles = 0;
        while (bytes_rx < b0 + 3 && cycles < 20000) begin
            @(negedge CCLK);
            cycles++;
        end
        check("reached_byte3", bytes_rx >= b0 + 3, bytes_rx - b0, 3);
        repeat (3 * CLKS) @(negedge CCLK);
        #2 RST_N = 1'b0;
        reset_epoch++;
        #1;
        check_reset_state();
        exp_bytes.delete();
        exp_cent.delete();
        repeat (5) @(negedge CCLK);
        #2 RST_N = 1'b1;
        repeat (12 * CLKS) @(negedge CCLK);
        run_txn(7, 700, 1400, 4, 0);

        for (int i = 0; i < 6; i++) begin
            s = (i % 2 == 0) ? $urandom_range(1, 50) : $urandom_range(1, 20'hFFFFF);
            if (i == 5) s = 0;
            sx = $urandom & 32'h0FFFFFFF;
            sy = $urandom & 32'h0FFFFFFF;
            run_txn(s, sx, sy, $urandom_range(1, 40), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
